picorv32_freeahb_bridge: RTL and testbench

PICORV32_FREEAHB_BRIDGE -- requirements
Module: picorv32_freeahb_bridge

---
 rtl/picorv32_freeahb_bridge.sv | 180 ++++++++++++++++++
 tb/tb_picorv32_freeahb_bridge.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/picorv32_freeahb_bridge.sv
// picorv32_freeahb_bridge: PicoRV32 native memory port to FreeAHB master request port.
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   mem_valid/instr/addr/wdata/wstrb -> PicoRV32 request; mem_ready/mem_rdata <- registered response
//   freeahb_valid/addr/wdata/size/write/read/min_len/cont/prot/lock -> FreeAHB request
//   freeahb_next/ready/rdata/result_addr <- FreeAHB response (result_addr unused)
//   bus_timeout                one-cycle pulse when a wait-state limit aborts a transaction
module picorv32_freeahb_bridge #(
    parameter bit          BIG_ENDIAN_AHB = 1'b1,
    parameter bit          MERGE_WRITES   = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        freeahb_valid,
    output logic [31:0] freeahb_addr,
    output logic [31:0] freeahb_wdata,
    output logic [2:0]  freeahb_size,
    output logic        freeahb_write,
    output logic        freeahb_read,
    output logic [31:0] freeahb_min_len,
    output logic        freeahb_cont,
    output logic [3:0]  freeahb_prot,
    output logic        freeahb_lock,
    input  logic        freeahb_next,
    input  logic        freeahb_ready,
    input  logic [31:0] freeahb_rdata,
    input  logic [31:0] freeahb_result_addr,
    output logic        bus_timeout
);
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_ISSUE, WR_WAIT, DONE} state_t;

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [31:0] base;
    logic [3:0]  rem;
    logic        instr_q;
    logic        gone_q;
    logic [31:0] cnt;
    logic [3:0]  src;
    logic [3:0]  src_n;
    logic [1:0]  lane;
    logic        word;
    logic        half;
    logic [2:0]  step_size;
    logic [31:0] step_addr;
    logic        gone;
    logic        to;
    logic        unused_ok;

    function automatic logic [31:0] swap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    assign freeahb_min_len = 32'd1;
    assign freeahb_cont    = 1'b0;
    assign freeahb_lock    = 1'b0;
    assign freeahb_prot    = {3'b000, ~instr_q};
    assign unused_ok       = ^freeahb_result_addr;

    // Write steps are taken from a mask of still-pending lanes: clear lanes below the
    // lowest set bit are skipped in the same cycle, so no bus cycle is wasted on them.
    always_comb begin
        src       = (state == IDLE) ? mem_wstrb : rem;
        lane      = src[0] ? 2'd0 : src[1] ? 2'd1 : src[2] ? 2'd2 : 2'd3;
        word      = MERGE_WRITES && src == 4'hF;
        half      = MERGE_WRITES && !word && !lane[0] && src[{lane[1], 1'b1}];
        step_size = word ? 3'b010 : half ? 3'b001 : 3'b000;
        src_n     = word ? 4'h0 : half ? (src & ~(4'b0011 << lane)) : (src & ~(4'b0001 << lane));
        step_addr = ((state == IDLE) ? {mem_addr[31:2], 2'b00} : base) + {30'd0, lane};
        gone      = gone_q || !mem_valid;
        to        = TIMEOUT_CYCLES != 0 && cnt == TO_LAST;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            base          <= '0;
            rem           <= '0;
            instr_q       <= 1'b0;
            gone_q        <= 1'b0;
            cnt           <= '0;
            freeahb_valid <= 1'b0;
            freeahb_addr  <= '0;
            freeahb_wdata <= '0;
            freeahb_size  <= '0;
            freeahb_write <= 1'b0;
            freeahb_read  <= 1'b0;
            mem_ready     <= 1'b0;
            mem_rdata     <= '0;
            bus_timeout   <= 1'b0;
        end else begin
            mem_ready   <= 1'b0;
            bus_timeout <= 1'b0;
            cnt         <= cnt + 32'd1;
            // Once the core withdraws its request it stays withdrawn for this transaction.
            gone_q      <= gone;
            if (state != IDLE && state != DONE && to) begin
                freeahb_valid <= 1'b0;
                freeahb_read  <= 1'b0;
                freeahb_write <= 1'b0;
                bus_timeout   <= 1'b1;
                if (freeahb_read)
                    mem_rdata <= ERR_RDATA;
                mem_ready <= !gone;
                state     <= gone ? IDLE : DONE;
                cnt       <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt <= '0;
                        if (mem_valid && !mem_ready) begin
                            base          <= {mem_addr[31:2], 2'b00};
                            instr_q       <= mem_instr;
                            gone_q        <= 1'b0;
                            freeahb_wdata <= BIG_ENDIAN_AHB ? swap(mem_wdata) : mem_wdata;
                            freeahb_valid <= 1'b1;
                            if (mem_wstrb == 4'h0) begin
                                freeahb_read <= 1'b1;
                                freeahb_size <= 3'b010;
                                freeahb_addr <= mem_addr;
                                state        <= RD_REQ;
                            end else begin
                                freeahb_write <= 1'b1;
                                freeahb_size  <= step_size;
                                freeahb_addr  <= step_addr;
                                rem           <= src_n;
                                state         <= WR_ISSUE;
                            end
                        end
                    end
                    RD_REQ: if (freeahb_next) begin
                        freeahb_valid <= 1'b0;
                        state         <= RD_WAIT;
                        cnt           <= '0;
                    end
                    RD_WAIT: if (freeahb_ready) begin
                        mem_rdata    <= BIG_ENDIAN_AHB ? swap(freeahb_rdata) : freeahb_rdata;
                        freeahb_read <= 1'b0;
                        mem_ready    <= !gone;
                        state        <= gone ? IDLE : DONE;
                        cnt          <= '0;
                    end
                    WR_ISSUE: if (freeahb_next) begin
                        freeahb_valid <= 1'b0;
                        state         <= WR_WAIT;
                        cnt           <= '0;
                    end
                    WR_WAIT: if (freeahb_next) begin
                        cnt <= '0;
                        if (rem != 4'h0 && !gone) begin
                            freeahb_valid <= 1'b1;
                            freeahb_addr  <= step_addr;
                            freeahb_size  <= step_size;
                            rem           <= src_n;
                            state         <= WR_ISSUE;
                        end else begin
                            freeahb_write <= 1'b0;
                            mem_ready     <= !gone;
                            state         <= gone ? IDLE : DONE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_picorv32_freeahb_bridge.sv
// tb_picorv32_freeahb_bridge: self-checking bench for picorv32_freeahb_bridge.
// Instance 0: big-endian, merging, 8-cycle timeout. Instance 1: little-endian, byte-only, no timeout.
module tb_picorv32_freeahb_bridge;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        mv[2], mi[2], mr[2], fv[2], fw[2], fr[2], fc[2], fl[2], nx[2], rdy[2], bt[2];
    logic [31:0] ma[2], mwd[2], mrd[2], fa[2], fwd[2], fml[2], frd[2];
    logic [3:0]  mws[2], fp[2];
    logic [2:0]  fsz[2];
    logic [31:0] fra = 32'h0;

    picorv32_freeahb_bridge #(.BIG_ENDIAN_AHB(1'b1), .MERGE_WRITES(1'b1), .TIMEOUT_CYCLES(8)) u0 (
        .clk(clk), .reset(reset), .mem_valid(mv[0]), .mem_instr(mi[0]), .mem_addr(ma[0]),
        .mem_wdata(mwd[0]), .mem_wstrb(mws[0]), .mem_ready(mr[0]), .mem_rdata(mrd[0]),
        .freeahb_valid(fv[0]), .freeahb_addr(fa[0]), .freeahb_wdata(fwd[0]), .freeahb_size(fsz[0]),
        .freeahb_write(fw[0]), .freeahb_read(fr[0]), .freeahb_min_len(fml[0]), .freeahb_cont(fc[0]),
        .freeahb_prot(fp[0]), .freeahb_lock(fl[0]), .freeahb_next(nx[0]), .freeahb_ready(rdy[0]),
        .freeahb_rdata(frd[0]), .freeahb_result_addr(fra), .bus_timeout(bt[0]));

    picorv32_freeahb_bridge #(.BIG_ENDIAN_AHB(1'b0), .MERGE_WRITES(1'b0), .TIMEOUT_CYCLES(0)) u1 (
        .clk(clk), .reset(reset), .mem_valid(mv[1]), .mem_instr(mi[1]), .mem_addr(ma[1]),
        .mem_wdata(mwd[1]), .mem_wstrb(mws[1]), .mem_ready(mr[1]), .mem_rdata(mrd[1]),
        .freeahb_valid(fv[1]), .freeahb_addr(fa[1]), .freeahb_wdata(fwd[1]), .freeahb_size(fsz[1]),
        .freeahb_write(fw[1]), .freeahb_read(fr[1]), .freeahb_min_len(fml[1]), .freeahb_cont(fc[1]),
        .freeahb_prot(fp[1]), .freeahb_lock(fl[1]), .freeahb_next(nx[1]), .freeahb_ready(rdy[1]),
        .freeahb_rdata(frd[1]), .freeahb_result_addr(fra), .bus_timeout(bt[1]));

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  size;
        logic        wr;
        logic        rd;
        logic [31:0] wd;
        logic [3:0]  prot;
    } xfer_t;

    typedef struct {
        int          k;
        logic [31:0] a, wd, rdin;
        logic [3:0]  ws;
        logic        ins;
        int          n;
        logic [7:0]  offs;
        logic [11:0] szs;
        logic [31:0] exp_wd, exp_rd;
    } vec_t;

    xfer_t       log_q[$], exp_q[$];
    int          n_chk = 0, n_err = 0;
    int          n_ready, n_to, rd_start, ready_at, vcyc;
    bit          stable_ok;
    logic [31:0] got_rd;
    vec_t        tbl[9];

    function automatic logic [31:0] swap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic xfer_t cur_xfer(input int k);
        xfer_t x;
        x.addr = fa[k]; x.size = fsz[k]; x.wr = fw[k]; x.rd = fr[k]; x.wd = fwd[k]; x.prot = fp[k];
        return x;
    endfunction

    // Reference: walk the lanes with a pointer and apply the word/halfword/byte rules directly.
    function automatic void model(input int k, input logic [31:0] a, input logic [31:0] wd,
                                  input logic [3:0] ws, input logic ins);
        xfer_t x;
        int    p;
        bit    mg;
        mg = (k == 0);
        exp_q.delete();
        p = 0;
        x.prot = ins ? 4'h0 : 4'h1;
        x.wd = (k == 0) ? swap(wd) : wd;
        if (ws == 4'h0) begin
            x.addr = a; x.size = 3'd2; x.wr = 1'b0; x.rd = 1'b1;
            exp_q.push_back(x);
            return;
        end
        x.wr = 1'b1; x.rd = 1'b0;
        while (p < 4) begin
            x.addr = {a[31:2], 2'b00} + 32'(p);
            if (mg && p == 0 && ws == 4'hF) begin
                x.size = 3'd2; exp_q.push_back(x); p += 4;
            end else if (mg && p % 2 == 0 && ws[p] && ws[p+1]) begin
                x.size = 3'd1; exp_q.push_back(x); p += 2;
            end else begin
                if (ws[p]) begin x.size = 3'd0; exp_q.push_back(x); end
                p += 1;
            end
        end
    endfunction

    task automatic cmp_log(input string tag);
        chk($sformatf("%s.count", tag), 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s.addr%0d", tag, i), log_q[i].addr, exp_q[i].addr);
            chk($sformatf("%s.size%0d", tag, i), 32'(log_q[i].size), 32'(exp_q[i].size));
            chk($sformatf("%s.dir%0d", tag, i), {30'd0, log_q[i].wr, log_q[i].rd}, {30'd0, exp_q[i].wr, exp_q[i].rd});
            chk($sformatf("%s.prot%0d", tag, i), 32'(log_q[i].prot), 32'(exp_q[i].prot));
            if (exp_q[i].wr)
                chk($sformatf("%s.wdata%0d", tag, i), log_q[i].wd, exp_q[i].wd);
        end
    endtask

    // Drives one request on instance k and plays the FreeAHB side; lat < 0 means never ready.
    task automatic run(input int k, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       input logic ins, input logic [31:0] rdin, input int stall, input int lat, input bit drop);
        int    stall_left, lat_left;
        bit    done, dropped, have;
        xfer_t cur, first;
        log_q.delete();
        n_ready = 0; n_to = 0; rd_start = -1; ready_at = -1; vcyc = 0; stable_ok = 1'b1;
        done = 0; dropped = 0; have = 0; stall_left = stall; lat_left = lat;
        mv[k] = 1'b1; ma[k] = a; mwd[k] = wd; mws[k] = ws; mi[k] = ins; frd[k] = rdin;
        for (int c = 0; c < 200 && !done; c++) begin
            @(posedge clk); #1;
            nx[k] = 1'b0; rdy[k] = 1'b0;
            if (mr[k]) begin n_ready++; got_rd = mrd[k]; ready_at = c; mv[k] = 1'b0; done = 1; end
            if (bt[k]) n_to++;
            if (fv[k]) begin
                cur = cur_xfer(k);
                if (log_q.size() == 0) vcyc++;
                if (!have) begin first = cur; have = 1; end
                else if (cur !== first) stable_ok = 1'b0;
                if (stall_left > 0) stall_left--;
                else begin
                    nx[k] = 1'b1; log_q.push_back(cur); have = 0;
                    if (drop) begin mv[k] = 1'b0; dropped = 1; end
                end
            end else if (fw[k]) nx[k] = 1'b1;
            else if (fr[k]) begin
                if (rd_start < 0) rd_start = c;
                if (lat_left == 0) rdy[k] = 1'b1;
                else if (lat_left > 0) lat_left--;
            end else if (dropped) done = 1;
        end
        if (!done) begin
            n_chk++; n_err++;
            $display("FAIL run_bound: inst %0d addr %h got no completion want completion", k, a);
        end
        mv[k] = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            nx[k] = 1'b0; rdy[k] = 1'b0;
            if (mr[k]) n_ready++;
            if (bt[k]) n_to++;
        end
    endtask

    task automatic chk_reset(input int k, input string tag);
        chk({tag, ".valid"}, 32'(fv[k]), 32'd0);
        chk({tag, ".addr"}, fa[k], 32'd0);
        chk({tag, ".wdata"}, fwd[k], 32'd0);
        chk({tag, ".size"}, 32'(fsz[k]), 32'd0);
        chk({tag, ".wr_rd"}, {30'd0, fw[k], fr[k]}, 32'd0);
        chk({tag, ".min_len"}, fml[k], 32'd1);
        chk({tag, ".cont_lock"}, {30'd0, fc[k], fl[k]}, 32'd0);
        chk({tag, ".prot"}, 32'(fp[k]), 32'd1);
        chk({tag, ".mem_ready"}, 32'(mr[k]), 32'd0);
        chk({tag, ".mem_rdata"}, mrd[k], 32'd0);
        chk({tag, ".bus_timeout"}, 32'(bt[k]), 32'd0);
    endtask

    initial begin
        int          k, seen_ww, extra_ready;
        logic [31:0] a, wd, rdin, ea;
        logic [3:0]  ws;
        logic        ins;
        tbl[0] = '{0, 32'h4000_0010, 32'h0,         32'h1122_3344, 4'h0, 1'b1, 1, 8'h00, 12'h002, 32'h0,         32'h4433_2211};
        tbl[1] = '{0, 32'h0000_0100, 32'hAABB_CCDD, 32'h0,         4'hF, 1'b0, 1, 8'h00, 12'h002, 32'hDDCC_BBAA, 32'h0};
        tbl[2] = '{0, 32'h0000_0100, 32'h1122_3344, 32'h0,         4'h7, 1'b0, 2, 8'h08, 12'h001, 32'h4433_2211, 32'h0};
        tbl[3] = '{0, 32'h0000_0100, 32'h1122_3344, 32'h0,         4'hA, 1'b0, 2, 8'h0D, 12'h000, 32'h4433_2211, 32'h0};
        tbl[4] = '{1, 32'h0000_0100, 32'hCAFE_F00D, 32'h0,         4'hF, 1'b0, 4, 8'hE4, 12'h000, 32'hCAFE_F00D, 32'h0};
        tbl[5] = '{1, 32'h2000_0004, 32'h0,         32'h0102_0304, 4'h0, 1'b0, 1, 8'h00, 12'h002, 32'h0,         32'h0102_0304};
        tbl[6] = '{0, 32'h0000_0300, 32'h1122_3344, 32'h0,         4'hC, 1'b0, 1, 8'h02, 12'h001, 32'h4433_2211, 32'h0};
        tbl[7] = '{0, 32'h0000_0304, 32'h1122_3344, 32'h0,         4'hB, 1'b1, 2, 8'h0C, 12'h001, 32'h4433_2211, 32'h0};
        tbl[8] = '{1, 32'h0000_0104, 32'h1122_3344, 32'h0,         4'h6, 1'b0, 2, 8'h09, 12'h000, 32'h1122_3344, 32'h0};
        for (int i = 0; i < 2; i++) begin
            mv[i] = 0; mi[i] = 0; ma[i] = 0; mwd[i] = 0; mws[i] = 0; nx[i] = 0; rdy[i] = 0; frd[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk_reset(0, "reset0");
        chk_reset(1, "reset1");
        reset = 1'b0;
        @(posedge clk); #1;

        foreach (tbl[t]) begin
            run(tbl[t].k, tbl[t].a, tbl[t].wd, tbl[t].ws, tbl[t].ins, tbl[t].rdin, 0, 1, 1'b0);
            chk($sformatf("tbl%0d.count", t), 32'(log_q.size()), 32'(tbl[t].n));
            for (int i = 0; i < tbl[t].n && i < log_q.size(); i++) begin
                ea = (tbl[t].ws == 4'h0) ? tbl[t].a : {tbl[t].a[31:2], 2'b00} + {30'd0, tbl[t].offs[2*i +: 2]};
                chk($sformatf("tbl%0d.addr%0d", t, i), log_q[i].addr, ea);
                chk($sformatf("tbl%0d.size%0d", t, i), 32'(log_q[i].size), 32'(tbl[t].szs[3*i +: 3]));
                chk($sformatf("tbl%0d.write%0d", t, i), 32'(log_q[i].wr), 32'(tbl[t].ws != 4'h0));
                chk($sformatf("tbl%0d.prot%0d", t, i), 32'(log_q[i].prot), tbl[t].ins ? 32'd0 : 32'd1);
                if (tbl[t].ws != 4'h0)
                    chk($sformatf("tbl%0d.wdata%0d", t, i), log_q[i].wd, tbl[t].exp_wd);
            end
            chk($sformatf("tbl%0d.ready_pulses", t), 32'(n_ready), 32'd1);
            chk($sformatf("tbl%0d.timeout", t), 32'(n_to), 32'd0);
            if (tbl[t].ws == 4'h0)
                chk($sformatf("tbl%0d.rdata", t), got_rd, tbl[t].exp_rd);
        end

        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 1);
            a = $urandom; wd = $urandom; rdin = $urandom;
            ws = 4'($urandom_range(0, 15));
            ins = 1'($urandom_range(0, 1));
            model(k, a, wd, ws, ins);
            run(k, a, wd, ws, ins, rdin, $urandom_range(0, 3), $urandom_range(0, 4), 1'b0);
            cmp_log($sformatf("rnd%0d", i));
            chk($sformatf("rnd%0d.ready_pulses", i), 32'(n_ready), 32'd1);
            chk($sformatf("rnd%0d.timeout", i), 32'(n_to), 32'd0);
            if (ws == 4'h0)
                chk($sformatf("rnd%0d.rdata", i), got_rd, (k == 0) ? swap(rdin) : rdin);
        end

        run(0, 32'h0000_0500, 32'h0, 4'h0, 1'b0, 32'h5566_7788, 5, 0, 1'b0);
        chk("stall.valid_cycles", 32'(vcyc), 32'd6);
        chk("stall.stable", 32'(stable_ok), 32'd1);
        chk("stall.count", 32'(log_q.size()), 32'd1);
        chk("stall.rdata", got_rd, 32'h8877_6655);

        run(0, 32'h0000_0600, 32'h0, 4'h0, 1'b0, 32'h0, 0, -1, 1'b0);
        chk("timeout.pulses", 32'(n_to), 32'd1);
        chk("timeout.rdata", got_rd, 32'hDEAD_BEEF);
        chk("timeout.ready_pulses", 32'(n_ready), 32'd1);
        chk("timeout.ready_cycle", 32'(ready_at - rd_start), 32'd8);

        model(1, 32'h0000_0400, 32'h0A0B_0C0D, 4'h7, 1'b0);
        run(1, 32'h0000_0400, 32'h0A0B_0C0D, 4'h7, 1'b0, 32'h0, 0, 0, 1'b1);
        chk("drop.count", 32'(log_q.size()), 32'd1);
        if (log_q.size() > 0) chk("drop.addr", log_q[0].addr, exp_q[0].addr);
        chk("drop.ready_pulses", 32'(n_ready), 32'd0);
        chk("drop.idle", {29'd0, fv[1], fw[1], fr[1]}, 32'd0);

        mv[1] = 1'b1; ma[1] = 32'h0000_0200; mws[1] = 4'h7; mwd[1] = 32'h1234_5678; mi[1] = 1'b0;
        seen_ww = 0; extra_ready = 0;
        for (int c = 0; c < 50 && seen_ww == 0; c++) begin
            @(posedge clk); #1;
            nx[1] = 1'b0;
            if (mr[1]) extra_ready++;
            if (fv[1]) nx[1] = 1'b1;
            else if (fw[1]) seen_ww = 1;
        end
        chk("rst.reached_wr_wait", 32'(seen_ww), 32'd1);
        reset = 1'b1; nx[1] = 1'b0; mv[1] = 1'b0;
        #1;
        chk_reset(1, "rst_mid");
        @(posedge clk); #1;
        if (mr[1]) extra_ready++;
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (mr[1]) extra_ready++;
        end
        chk("rst.no_ready", 32'(extra_ready), 32'd0);
        chk("rst.idle", {29'd0, fv[1], fw[1], fr[1]}, 32'd0);
        run(1, 32'h0000_0208, 32'h0, 4'h0, 1'b1, 32'h7766_5544, 1, 2, 1'b0);
        chk("rst.read_count", 32'(log_q.size()), 32'd1);
        chk("rst.read_rdata", got_rd, 32'h7766_5544);
        chk("rst.read_ready", 32'(n_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
